// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: frame FSM encoding,
// bit-order constants and the effective word-length helper.
package spi_pkg;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t SPI_IDLE   = 2'd0;
    localparam spi_state_t SPI_ACTIVE = 2'd1;
    localparam spi_state_t SPI_DONE   = 2'd2;

    localparam logic SPI_MSB_FIRST = 1'b0;
    localparam logic SPI_LSB_FIRST = 1'b1;

    // A programmed length of 0, or anything wider than the datapath,
    // means a full-width word.
    function automatic int unsigned spi_eff_len(input int unsigned len,
                                                input int unsigned data_w);
        if (len == 0 || len > data_w) return data_w;
        return len;
    endfunction

endpackage

// File: rtl/spi_word_align.sv
// Combinational word alignment for the SPI datapath.
//   i_tx_len/i_tx_lsb_first/i_tx_data -> o_tx_aligned : TX word placed in the
//     shift register (MSB-first: left-aligned, LSB-first: right-aligned, bits
//     above the length cleared).
//   i_rx_len/i_rx_word -> o_rx_aligned : received word right-aligned and
//     zero-extended to DATA_W.
module spi_word_align
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic [CNT_W-1:0]  i_tx_len,
    input  logic              i_tx_lsb_first,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic [DATA_W-1:0] o_tx_aligned,
    input  logic [CNT_W-1:0]  i_rx_len,
    input  logic [DATA_W-1:0] i_rx_word,
    output logic [DATA_W-1:0] o_rx_aligned
);

    // Number of unused bit positions above the word (lengths are 1..DATA_W).
    logic [31:0] tx_pad;
    logic [31:0] rx_pad;

    always_comb begin
        tx_pad = DATA_W - 32'(i_tx_len);
        rx_pad = DATA_W - 32'(i_rx_len);
        if (i_tx_lsb_first == SPI_LSB_FIRST) begin
            o_tx_aligned = i_tx_data & ({DATA_W{1'b1}} >> tx_pad);
        end else begin
            o_tx_aligned = i_tx_data << tx_pad;
        end
        o_rx_aligned = i_rx_word & ({DATA_W{1'b1}} >> rx_pad);
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: programmable word length, MSB/LSB-first,
// CPHA 0/1, internal loopback, ready/valid TX and RX with sticky overrun.
//   TX side : i_tx_valid/i_tx_data/o_tx_ready, mode inputs latched at load.
//   SCLK    : i_leading_edge/i_trailing_edge strobes from the edge generator.
//   Serial  : i_MISO in, o_MOSI out (registered).
//   Status  : o_frame_active, o_frame_done (pulse), i_abort.
//   RX side : o_rx_valid/o_rx_data/i_rx_ready, o_rx_overrun/i_ovr_clr.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic              i_loopback,
    input  logic [CNT_W-1:0]  i_word_len,
    input  logic              i_tx_valid,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_ready,
    input  logic              i_abort,
    input  logic              i_leading_edge,
    input  logic              i_trailing_edge,
    input  logic              i_MISO,
    output logic              o_MOSI,
    output logic              o_frame_active,
    output logic              o_frame_done,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    input  logic              i_rx_ready,
    output logic              o_rx_overrun,
    input  logic              i_ovr_clr
);

    spi_state_t        st_q, st_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              loop_q, loop_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              mosi_q, mosi_d;
    logic              rx_valid_q, rx_valid_d;
    logic              ovr_q, ovr_d;

    logic [CNT_W-1:0]  len_eff;
    logic [DATA_W-1:0] tx_aligned;
    logic [DATA_W-1:0] rx_aligned;
    logic [DATA_W-1:0] tx_shifted;
    logic [CNT_W-1:0]  tcnt_inc;
    logic              lead, trail, sample_bit, rx_write, ovr_set;

    assign len_eff = CNT_W'(spi_eff_len(32'(i_word_len), DATA_W));

    spi_word_align #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_align (
        .i_tx_len       (len_eff),
        .i_tx_lsb_first (i_lsb_first),
        .i_tx_data      (i_tx_data),
        .o_tx_aligned   (tx_aligned),
        .i_rx_len       (len_q),
        .i_rx_word      (rx_sh_q),
        .o_rx_aligned   (rx_aligned)
    );

    always_comb begin
        st_d       = st_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        loop_d     = loop_q;
        len_d      = len_q;
        tcnt_d     = tcnt_q;
        scnt_d     = scnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        mosi_d     = mosi_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        rx_write   = 1'b0;
        ovr_set    = 1'b0;

        // Simultaneous strobes are illegal; the leading edge wins.
        lead       = i_leading_edge;
        trail      = i_trailing_edge & ~i_leading_edge;
        sample_bit = loop_q ? mosi_q : i_MISO;
        tx_shifted = (lsb_q == SPI_LSB_FIRST) ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        tcnt_inc   = tcnt_q + 1'b1;

        case (st_q)
            SPI_IDLE: begin
                if (i_tx_valid) begin
                    st_d    = SPI_ACTIVE;
                    cpha_d  = i_cpha;
                    lsb_d   = i_lsb_first;
                    loop_d  = i_loopback;
                    len_d   = len_eff;
                    tcnt_d  = '0;
                    scnt_d  = '0;
                    rx_sh_d = '0;
                    tx_sh_d = tx_aligned;
                    // CPHA=0 presents bit 1 straight away; CPHA=1 waits for
                    // the first leading edge.
                    if (i_cpha) mosi_d = 1'b0;
                    else mosi_d = (i_lsb_first == SPI_LSB_FIRST) ? tx_aligned[0]
                                                                 : tx_aligned[DATA_W-1];
                end
            end
            SPI_ACTIVE: begin
                if (i_abort) begin
                    st_d   = SPI_IDLE;
                    mosi_d = 1'b0;
                end else begin
                    // The edge that samples depends on CPHA; the other drives.
                    if ((lead && !cpha_q) || (trail && cpha_q)) begin
                        if (scnt_q < len_q) begin
                            scnt_d = scnt_q + 1'b1;
                            if (lsb_q == SPI_LSB_FIRST)
                                rx_sh_d = rx_sh_q | ({{(DATA_W-1){1'b0}}, sample_bit} << scnt_q);
                            else
                                rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_bit};
                        end
                    end
                    if (lead && cpha_q) begin
                        mosi_d  = (lsb_q == SPI_LSB_FIRST) ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
                        tx_sh_d = tx_shifted;
                    end
                    if (trail) begin
                        tcnt_d = tcnt_inc;
                        if (tcnt_inc == len_q) begin
                            st_d = SPI_DONE;
                        end else if (!cpha_q) begin
                            tx_sh_d = tx_shifted;
                            mosi_d  = (lsb_q == SPI_LSB_FIRST) ? tx_shifted[0]
                                                               : tx_shifted[DATA_W-1];
                        end
                    end
                end
            end
            SPI_DONE: begin
                st_d = SPI_IDLE;
                if (i_abort) mosi_d = 1'b0;
                else rx_write = 1'b1;
            end
            default: st_d = SPI_IDLE;
        endcase

        // A fresh word keeps valid high even if the old one is consumed now.
        if (rx_write) begin
            rx_data_d  = rx_aligned;
            rx_valid_d = 1'b1;
            ovr_set    = rx_valid_q & ~i_rx_ready;
        end else if (rx_valid_q && i_rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (ovr_set) ovr_d = 1'b1;
        else if (i_ovr_clr) ovr_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= SPI_IDLE;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            loop_q     <= 1'b0;
            len_q      <= '0;
            tcnt_q     <= '0;
            scnt_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            loop_q     <= loop_d;
            len_q      <= len_d;
            tcnt_q     <= tcnt_d;
            scnt_q     <= scnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_tx_ready     = (st_q == SPI_IDLE);
    assign o_frame_active = (st_q == SPI_ACTIVE);
    assign o_frame_done   = (st_q == SPI_DONE) & ~i_abort;
    assign o_MOSI         = mosi_q;
    assign o_rx_valid     = rx_valid_q;
    assign o_rx_data      = rx_data_q;
    assign o_rx_overrun   = ovr_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine (DATA_W=16): expected MOSI bits and RX
// words are queued when a frame is driven and popped where the DUT emits them.
module tb_spi_shift_engine;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 5;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_cpha, i_lsb_first, i_loopback;
    logic [CNT_W-1:0]  i_word_len;
    logic              i_tx_valid;
    logic [DATA_W-1:0] i_tx_data;
    logic              o_tx_ready;
    logic              i_abort, i_leading_edge, i_trailing_edge, i_MISO;
    logic              o_MOSI, o_frame_active, o_frame_done, o_rx_valid;
    logic [DATA_W-1:0] o_rx_data;
    logic              i_rx_ready, o_rx_overrun, i_ovr_clr;

    int vectors     = 0;
    int miscompares = 0;

    logic              exp_bits[$];
    logic [DATA_W-1:0] exp_rx[$];

    always #5 i_clk = ~i_clk;

    spi_shift_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cpha(i_cpha), .i_lsb_first(i_lsb_first), .i_loopback(i_loopback),
        .i_word_len(i_word_len), .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data),
        .o_tx_ready(o_tx_ready), .i_abort(i_abort),
        .i_leading_edge(i_leading_edge), .i_trailing_edge(i_trailing_edge),
        .i_MISO(i_MISO), .o_MOSI(o_MOSI), .o_frame_active(o_frame_active),
        .o_frame_done(o_frame_done), .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data),
        .i_rx_ready(i_rx_ready), .o_rx_overrun(o_rx_overrun), .i_ovr_clr(i_ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_ready"}, o_tx_ready, 1);
        chk({tag, "_active"}, o_frame_active, 0);
        chk({tag, "_done"}, o_frame_done, 0);
        chk({tag, "_mosi"}, o_MOSI, 0);
        chk({tag, "_rx_valid"}, o_rx_valid, 0);
        chk({tag, "_rx_data"}, o_rx_data, 0);
        chk({tag, "_overrun"}, o_rx_overrun, 0);
    endtask

    // stop_kind: 0 = run to completion, 1 = abort, 2 = reset; stop_at is the
    // number of trailing edges seen before stopping.
    task automatic frame(input logic cpha, input logic lsb, input logic loop,
                         input logic [CNT_W-1:0] wl, input logic [DATA_W-1:0] tx,
                         input logic [DATA_W-1:0] miso, input logic rdy,
                         input int stop_at, input int stop_kind);
        int          len;
        logic [15:0] mask;
        logic        last_bit;
        logic        rv_before;
        len      = (wl == 0 || wl > 16) ? 16 : int'(wl);
        mask     = 16'hFFFF >> (16 - len);
        last_bit = lsb ? tx[len-1] : tx[0];
        for (int i = 0; i < len; i++) exp_bits.push_back(lsb ? tx[i] : tx[len-1-i]);
        if (stop_kind == 0) exp_rx.push_back((loop ? tx : miso) & mask);

        i_rx_ready = rdy;
        chk("tx_ready_idle", o_tx_ready, 1);
        i_cpha = cpha; i_lsb_first = lsb; i_loopback = loop; i_word_len = wl;
        i_tx_data = tx; i_tx_valid = 1'b1;
        tick();
        // Mode/length/data changes mid-frame must not matter.
        i_tx_valid = 1'b0; i_tx_data = 16'($urandom);
        i_cpha = ~cpha; i_lsb_first = ~lsb; i_loopback = ~loop; i_word_len = 5'($urandom);
        chk("active", o_frame_active, 1);
        chk("tx_ready_busy", o_tx_ready, 0);

        for (int i = 0; i < len; i++) begin
            i_MISO = loop ? ~(lsb ? miso[i] : miso[len-1-i]) : (lsb ? miso[i] : miso[len-1-i]);
            i_leading_edge = 1'b1;
            if (!cpha) chk("mosi_cpha0", o_MOSI, exp_bits.pop_front());
            tick();
            i_leading_edge = 1'b0;
            if (cpha) chk("mosi_cpha1", o_MOSI, exp_bits.pop_front());
            tick();
            i_trailing_edge = 1'b1;
            tick();
            i_trailing_edge = 1'b0;
            if (i == len - 1) begin
                chk("frame_done", o_frame_done, 1);
                if (!cpha) chk("mosi_hold", o_MOSI, last_bit);
            end else begin
                chk("no_early_done", o_frame_done, 0);
            end
            if (stop_kind == 1 && i + 1 == stop_at) begin
                rv_before = o_rx_valid;
                i_abort = 1'b1;
                #1;
                chk("abort_no_done", o_frame_done, 0);
                tick();
                i_abort = 1'b0;
                chk("abort_tx_ready", o_tx_ready, 1);
                chk("abort_active", o_frame_active, 0);
                chk("abort_mosi", o_MOSI, 0);
                chk("abort_done", o_frame_done, 0);
                chk("abort_rx_valid", o_rx_valid, rv_before);
                exp_bits.delete();
                return;
            end
            if (stop_kind == 2 && i + 1 == stop_at) begin
                #2;
                i_rst_n = 1'b0;
                #1;
                check_reset_values("async_rst");
                tick();
                tick();
                i_rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    i_trailing_edge = k[0];
                    i_leading_edge  = ~k[0];
                    tick();
                    chk("post_rst_done", o_frame_done, 0);
                    chk("post_rst_active", o_frame_active, 0);
                end
                i_trailing_edge = 1'b0;
                i_leading_edge  = 1'b0;
                exp_bits.delete();
                return;
            end
            tick();
        end

        chk("rx_valid", o_rx_valid, 1);
        chk("rx_data", o_rx_data, exp_rx.pop_front());
        chk("done_cleared", o_frame_done, 0);
        if (rdy) begin
            tick();
            chk("rx_consumed", o_rx_valid, 0);
        end
        i_rx_ready = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0; i_loopback = 1'b0;
        i_word_len = '0; i_tx_valid = 1'b0; i_tx_data = '0; i_abort = 1'b0;
        i_leading_edge = 1'b0; i_trailing_edge = 1'b0; i_MISO = 1'b0;
        i_rx_ready = 1'b0; i_ovr_clr = 1'b0;
        #12;
        check_reset_values("reset");
        tick();
        i_rst_n = 1'b1;
        tick();

        // 1: L=8, MSB-first, CPHA=0
        frame(1'b0, 1'b0, 1'b0, 5'd8, 16'h00A5, 16'h003C, 1'b1, 0, 0);
        // 2: L=0 (16), LSB-first, CPHA=1, loopback; MISO driven with inverted data
        frame(1'b1, 1'b1, 1'b1, 5'd0, 16'h8001, 16'h0000, 1'b1, 0, 0);
        // 3: L=5, MSB-first, MISO all ones; leaves rx_valid set
        frame(1'b0, 1'b0, 1'b0, 5'd5, 16'hFFF3, 16'hFFFF, 1'b0, 0, 0);
        chk("t3_overrun", o_rx_overrun, 0);
        // 5: abort after 3 trailing edges, then a normal frame (length clamped)
        frame(1'b0, 1'b0, 1'b0, 5'd16, 16'hBEEF, 16'h1234, 1'b0, 3, 1);
        chk("t5_rx_data_kept", o_rx_data, 16'h001F);
        frame(1'b1, 1'b0, 1'b0, 5'd31, 16'hC35A, 16'h5AC3, 1'b1, 0, 0);
        chk("t5_overrun", o_rx_overrun, 0);
        // 4: back-to-back frames without consuming
        frame(1'b0, 1'b0, 1'b0, 5'd16, 16'h1111, 16'h1111, 1'b0, 0, 0);
        chk("t4_no_overrun_yet", o_rx_overrun, 0);
        frame(1'b0, 1'b0, 1'b0, 5'd16, 16'h2222, 16'h2222, 1'b0, 0, 0);
        chk("t4_overrun", o_rx_overrun, 1);
        i_ovr_clr = 1'b1;
        tick();
        i_ovr_clr = 1'b0;
        chk("t4_overrun_clr", o_rx_overrun, 0);
        chk("t4_valid_held", o_rx_valid, 1);
        chk("t4_data_held", o_rx_data, 16'h2222);
        i_rx_ready = 1'b1;
        tick();
        i_rx_ready = 1'b0;
        chk("t4_valid_cleared", o_rx_valid, 0);
        // 6: reset mid-frame, with rx_valid set beforehand
        frame(1'b0, 1'b1, 1'b0, 5'd3, 16'h0006, 16'h0005, 1'b0, 0, 0);
        frame(1'b0, 1'b0, 1'b0, 5'd16, 16'hFFFF, 16'hFFFF, 1'b0, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
